pellet_map_ctrl: RTL
====================

PELLET_MAP_CTRL -- requirements
Module: pellet_map_ctrl

Interface
REQ-001 SHALL have parameter POINTS, default 10, score increment per pellet eaten.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  single-cycle pulse that begins a level fill.
REQ-005 SHALL have ports rd_row, rd_col  input  3 each  renderer tile query, row and column.
REQ-006 SHALL have port rd_pellet  output  1  pellet present at the queried tile, registered.
REQ-007 SHALL have ports eat_req (input 1), eat_row (input 3) and eat_col (input 3)  game-logic request to eat the pellet at that tile.
REQ-008 SHALL have ports eat_ack (output 1) and eat_hit (output 1)  request accepted, and the tile held a pellet.
REQ-009 SHALL have port pellets_left  output  7  pellets remaining, range 0..64.
REQ-010 SHALL have ports score (output 16), level_clear (output 1) and busy (output 1).

Function
REQ-011 SHALL compute tile index = row*8+col, 0..63; PATH_MASK bit i=1 marks a walkable tile.
REQ-012 SHALL implement an FSM with states IDLE, FILL, PLAY and CLEAR.
REQ-013 SHALL perform these transitions: start in IDLE, PLAY or CLEAR goes to FILL; start during FILL is ignored.
REQ-014 SHALL in FILL write pellet[idx]=PATH_MASK[idx] for idx 0..63, one tile per cycle, for exactly 64 cycles, then enter PLAY.
REQ-015 SHALL load pellets_left=PELLET_TOTAL (22) on the cycle PLAY is entered.
REQ-016 SHALL hold busy=1 throughout FILL and only then.
REQ-017 SHALL return rd_pellet = pellet[rd_row*8+rd_col] one cycle after the query, and force rd_pellet=0 for queries issued in FILL or IDLE.
REQ-018 SHALL accept an eat request when eat_req=1, state=PLAY and eat_ack=0 in that cycle.
REQ-019 SHALL pulse eat_ack for one cycle in the cycle after acceptance; eat_hit is valid with eat_ack and 0 otherwise.
REQ-020 SHALL on an accepted request clear the tile and set eat_hit to the pre-clear bit.
REQ-021 SHALL on a hit decrement pellets_left and add POINTS to score, saturating at 16'hFFFF.
REQ-022 SHALL treat a request to an empty or wall tile as eat_hit=0, with no counter change.
REQ-023 SHALL resolve a same-cycle read and eat to the same tile read-before-write: rd_pellet shows the old value.
REQ-024 SHALL not accept eat requests outside PLAY; eat_ack stays 0 there.
REQ-025 SHALL move PLAY to CLEAR on the cycle pellets_left becomes 0, with level_clear=1 held until the next start.
REQ-026 SHALL give start priority over an eat_req arriving in the same PLAY cycle: the request is dropped and FILL begins.
REQ-027 SHALL preserve score across level fills.

Reset
REQ-028 SHALL on rst_n=0 at a clock edge enter IDLE and clear all pellet bits.
REQ-029 SHALL on reset drive pellets_left=0, score=0, rd_pellet=0, eat_ack=0, eat_hit=0, level_clear=0 and busy=0.
REQ-030 SHALL abort FILL immediately if reset arrives mid-fill, with the same values as REQ-029.

Configuration
REQ-031 SHALL provide macro PELLET_SCORE_EN.
REQ-032 SHALL when PELLET_SCORE_EN is defined implement the score counter per REQ-021/027.
REQ-033 SHALL when PELLET_SCORE_EN is undefined tie score to 0 with no score register; all other behaviour is unchanged.

Structure
REQ-034 SHALL place in shared package pacman_maze_pkg: MAZE_DIM=8, TILE_PX=60, PATH_MASK (64-bit), PELLET_TOTAL=22 and the FSM state enum.
REQ-035 SHALL place the 64x1 pellet storage in sub-module pellet_ram, with one sync read port and one write port and read-before-write behaviour.

Verification
REQ-036 SHALL test fill: reset, then start pulse -> busy=1 for 64 cycles, then pellets_left=22, and rd_pellet at (1,1)=1 and at (0,0)=0.
REQ-037 SHALL test eat: in PLAY, eat (1,1) -> eat_ack and eat_hit=1 next cycle, pellets_left=21, score=10; repeating (1,1) -> eat_hit=0, score stays 10.
REQ-038 SHALL test the same-cycle collision: read and eat of (3,2) together -> rd_pellet=1, and a follow-up read returns 0.
REQ-039 SHALL test clear: eat all 22 path tiles -> level_clear=1 and score=220; then start -> refill, score stays 220, level_clear=0.
REQ-040 SHALL test reset mid-fill: rst_n=0 at fill cycle 30 -> IDLE with busy=0, pellets_left=0 and score=0.
REQ-041 SHALL test start-versus-eat: start and eat_req in the same PLAY cycle -> no eat_ack, busy=1 next cycle.

Source files
------------

// File: rtl/pacman_maze_pkg.sv
// Maze constants shared by the pellet map: geometry, walkable-tile mask, pellet count
// and the controller state encoding.
package pacman_maze_pkg;

    localparam int MAZE_DIM     = 8;
    localparam int TILE_PX      = 60;
    localparam int TILES        = MAZE_DIM * MAZE_DIM;
    localparam int PELLET_TOTAL = 22;

    // Ring around rows 1/6 and columns 1/6, plus a two-tile spur at (3,2),(3,3).
    localparam logic [TILES-1:0] PATH_MASK = 64'h007E_4242_4E42_7E00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_PLAY  = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    function automatic logic [5:0] tile_idx(input logic [2:0] row, input logic [2:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/pellet_map_ctrl_if.sv
// Bundle of the pellet map's game-side signals: level start, renderer query, eat handshake
// and status; master drives requests, slave is the controller.
interface pellet_map_ctrl_if;

    logic        start;
    logic [2:0]  rd_row;
    logic [2:0]  rd_col;
    logic        rd_pellet;
    logic        eat_req;
    logic [2:0]  eat_row;
    logic [2:0]  eat_col;
    logic        eat_ack;
    logic        eat_hit;
    logic [6:0]  pellets_left;
    logic [15:0] score;
    logic        level_clear;
    logic        busy;

    modport master (
        output start, rd_row, rd_col, eat_req, eat_row, eat_col,
        input  rd_pellet, eat_ack, eat_hit, pellets_left, score, level_clear, busy
    );

    modport slave (
        input  start, rd_row, rd_col, eat_req, eat_row, eat_col,
        output rd_pellet, eat_ack, eat_hit, pellets_left, score, level_clear, busy
    );

endinterface

// File: rtl/pellet_ram.sv
// 64x1 pellet storage: registered read port, one write port that also exposes the
// bit it is about to overwrite; reads see the pre-write contents.
module pellet_ram
    import pacman_maze_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rd_en_i,
    input  logic [5:0] rd_addr_i,
    output logic       rd_data_o,
    input  logic       wr_en_i,
    input  logic [5:0] wr_addr_i,
    input  logic       wr_data_i,
    output logic       wr_old_o
);

    logic [TILES-1:0] mem_q;
    logic             rd_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q     <= '0;
            rd_data_q <= 1'b0;
        end else begin
            rd_data_q <= rd_en_i & mem_q[rd_addr_i];
            if (wr_en_i) begin
                mem_q[wr_addr_i] <= wr_data_i;
            end
        end
    end

    assign rd_data_o = rd_data_q;
    assign wr_old_o  = mem_q[wr_addr_i];

endmodule

// File: rtl/pellet_map_ctrl.sv
// Pellet map controller: fills the maze with pellets, serves renderer reads and resolves eats.
// Define PELLET_SCORE_EN to build the saturating score counter; otherwise score reads 0.
module pellet_map_ctrl
    import pacman_maze_pkg::*;
#(
    parameter int POINTS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    pellet_map_ctrl_if.slave bus
);

    state_e     state_q, state_d;
    logic [5:0] fill_cnt_q, fill_cnt_d;
    logic [6:0] left_q, left_d;
    logic       ack_q, ack_d;
    logic       hit_q, hit_d;
    logic       accept, fill_last, busy, level_clear, rd_en;
    logic       wr_en, wr_data, wr_old, rd_data;
    logic [5:0] wr_addr, eat_idx, rd_idx;

    assign eat_idx   = tile_idx(bus.eat_row, bus.eat_col);
    assign rd_idx    = tile_idx(bus.rd_row, bus.rd_col);
    assign fill_last = (fill_cnt_q == 6'(TILES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_CLEAR: begin
                if (bus.start) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (fill_last) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (bus.start) begin
                    state_d = ST_FILL;
                end else if (accept && wr_old && left_q == 7'd1) begin
                    state_d = ST_CLEAR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The write port is owned by the fill sweep in FILL and by accepted eats in PLAY.
    always_comb begin
        busy        = (state_q == ST_FILL);
        level_clear = (state_q == ST_CLEAR);
        rd_en       = (state_q == ST_PLAY) || (state_q == ST_CLEAR);
        accept      = bus.eat_req && (state_q == ST_PLAY) && !ack_q && !bus.start;
        wr_en       = 1'b0;
        wr_addr     = eat_idx;
        wr_data     = 1'b0;
        if (state_q == ST_FILL) begin
            wr_en   = 1'b1;
            wr_addr = fill_cnt_q;
            wr_data = PATH_MASK[fill_cnt_q];
        end else if (accept) begin
            wr_en   = 1'b1;
        end
    end

    pellet_ram u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_idx),
        .rd_data_o (rd_data),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .wr_old_o  (wr_old)
    );

    always_comb begin
        fill_cnt_d = (state_q == ST_FILL) ? fill_cnt_q + 6'd1 : 6'd0;
        ack_d      = accept;
        hit_d      = accept && wr_old;
        left_d     = left_q;
        if (state_q == ST_FILL && fill_last) begin
            left_d = 7'(PELLET_TOTAL);
        end else if (accept && wr_old) begin
            left_d = left_q - 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_cnt_q <= 6'd0;
            left_q     <= 7'd0;
            ack_q      <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            fill_cnt_q <= fill_cnt_d;
            left_q     <= left_d;
            ack_q      <= ack_d;
            hit_q      <= hit_d;
        end
    end

`ifdef PELLET_SCORE_EN
    logic [15:0] score_q, score_d;

    function automatic logic [15:0] sat_add(input logic [15:0] a);
        logic [16:0] sum;
        sum = {1'b0, a} + 17'(POINTS);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    always_comb begin
        score_d = score_q;
        if (accept && wr_old) begin
            score_d = sat_add(score_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            score_q <= 16'd0;
        end else begin
            score_q <= score_d;
        end
    end

    assign bus.score = score_q;
`else
    // Without scoring the increment has no effect; score is a constant zero.
    assign bus.score = 16'(POINTS) & 16'h0000;
`endif

    assign bus.rd_pellet    = rd_data;
    assign bus.eat_ack      = ack_q;
    assign bus.eat_hit      = hit_q;
    assign bus.pellets_left = left_q;
    assign bus.level_clear  = level_clear;
    assign bus.busy         = busy;

endmodule
